// File: rtl/dec_iter_ctrl_fsm.sv
// dec_iter_ctrl_fsm
// Decode-process controller placed in front of the VNU write-update handshake.
// Sequences one codeword decode: initial load, then per iteration a VNU read
// phase, a wait for the handshake's write-back window, and an iteration
// update, for up to MAX_ITER iterations.
//
// Ports:
//   read_clk            sole clock, rising edge
//   rst                 synchronous active-high reset
//   start_i             one-cycle pulse, starts a decode when idle
//   vnu_wr_i            write-window level from the handshake block
//   syndrome_ok_i       parity check result, sampled at ITER_END (early-term build only)
//   vnu_init_load_en_o  high during the initial-load phase
//   vnu_rd_finish_o     high from read completion until the write window opens
//   iter_update_o       level, toggled once per completed non-final iteration
//   iter_cnt_o          completed-iteration count of the current decode
//   busy_o              high whenever not idle
//   dec_done_o          one-cycle pulse at decode end (normal or aborted)
//   timeout_err_o       sticky write-window timeout flag
//
// Optional feature: define DEC_EARLY_TERM_EN to let syndrome_ok_i end the
// decode at any ITER_END. Without it the decode always runs MAX_ITER iterations.
//
// All outputs are registered and decoded from the next state, so they change
// on the same edge as the state they describe.

module dec_iter_ctrl_fsm #(
  parameter int MAX_ITER    = 10,
  parameter int INIT_CYCLES = 4,
  parameter int RD_CYCLES   = 8,
  parameter int WR_TIMEOUT  = 64,
  parameter int ITER_W      = 4
) (
  input  logic              read_clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              vnu_wr_i,
  input  logic              syndrome_ok_i,
  output logic              vnu_init_load_en_o,
  output logic              vnu_rd_finish_o,
  output logic              iter_update_o,
  output logic [ITER_W-1:0] iter_cnt_o,
  output logic              busy_o,
  output logic              dec_done_o,
  output logic              timeout_err_o
);

  // One phase counter serves the init, read and write-wait phases; they never
  // overlap, so it is sized for the longest of them.
  localparam int CNT_MAX = (WR_TIMEOUT > INIT_CYCLES)
                         ? ((WR_TIMEOUT > RD_CYCLES) ? WR_TIMEOUT : RD_CYCLES)
                         : ((INIT_CYCLES > RD_CYCLES) ? INIT_CYCLES : RD_CYCLES);
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]     INIT_LAST  = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0]     RD_LAST    = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0]     TMO_LAST   = CW'(WR_TIMEOUT - 1);
  localparam logic [ITER_W-1:0] MAX_ITER_W = ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_LOAD,
    S_VNU_READ,
    S_RD_FIN,
    S_WR_WAIT,
    S_ITER_END,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [ITER_W-1:0] iter_cnt_next;
  logic              iter_update_next;
  logic              timeout_err_next;

`ifndef DEC_EARLY_TERM_EN
  // Syndrome result has no effect in this build.
  logic syndrome_unused;
  assign syndrome_unused = syndrome_ok_i;
`endif

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    iter_cnt_next    = iter_cnt_o;
    iter_update_next = iter_update_o;
    timeout_err_next = timeout_err_o;

    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          state_next       = S_INIT_LOAD;
          iter_cnt_next    = '0;
          timeout_err_next = 1'b0;
        end
      end
      S_INIT_LOAD: begin
        if (cnt_reg == INIT_LAST) state_next = S_VNU_READ;
      end
      S_VNU_READ: begin
        if (cnt_reg == RD_LAST) state_next = S_RD_FIN;
      end
      S_RD_FIN: begin
        // An open write window wins over a coincident timeout.
        if (vnu_wr_i) begin
          state_next = S_WR_WAIT;
        end else if (cnt_reg == TMO_LAST) begin
          state_next       = S_DONE;
          timeout_err_next = 1'b1;
        end
      end
      S_WR_WAIT: begin
        if (!vnu_wr_i) begin
          state_next = S_ITER_END;
        end else if (cnt_reg == TMO_LAST) begin
          state_next       = S_DONE;
          timeout_err_next = 1'b1;
        end
      end
      S_ITER_END: begin
        // iter_cnt_o already holds the incremented count here.
`ifdef DEC_EARLY_TERM_EN
        if (syndrome_ok_i || iter_cnt_o == MAX_ITER_W) begin
          state_next = S_DONE;
        end else begin
          state_next       = S_VNU_READ;
          iter_update_next = ~iter_update_o;
        end
`else
        if (iter_cnt_o == MAX_ITER_W) begin
          state_next = S_DONE;
        end else begin
          state_next       = S_VNU_READ;
          iter_update_next = ~iter_update_o;
        end
`endif
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Count the iteration on the edge that enters ITER_END, saturating.
    if (state_next == S_ITER_END && iter_cnt_o != MAX_ITER_W) begin
      iter_cnt_next = iter_cnt_o + ITER_W'(1);
    end

    // Restart the phase counter on every state change except RD_FIN->WR_WAIT,
    // where the write-window timeout keeps running across both states.
    if (state_next != state_reg &&
        !(state_reg == S_RD_FIN && state_next == S_WR_WAIT)) begin
      cnt_next = '0;
    end else if (state_reg != S_IDLE) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge read_clk) begin
    if (rst) begin
      state_reg          <= S_IDLE;
      cnt_reg            <= '0;
      vnu_init_load_en_o <= 1'b0;
      vnu_rd_finish_o    <= 1'b0;
      iter_update_o      <= 1'b0;
      iter_cnt_o         <= '0;
      busy_o             <= 1'b0;
      dec_done_o         <= 1'b0;
      timeout_err_o      <= 1'b0;
    end else begin
      state_reg          <= state_next;
      cnt_reg            <= cnt_next;
      vnu_init_load_en_o <= (state_next == S_INIT_LOAD);
      vnu_rd_finish_o    <= (state_next == S_RD_FIN);
      iter_update_o      <= iter_update_next;
      iter_cnt_o         <= iter_cnt_next;
      busy_o             <= (state_next != S_IDLE);
      dec_done_o         <= (state_next == S_DONE);
      timeout_err_o      <= timeout_err_next;
    end
  end

endmodule
